wb_tmr_status: RTL

Wishbone slave in the user project area that holds the firmware-visible test status word (stage code and result flags) in triple-modular-redundant registers and drives it onto the GPIO pads monitored by the Wishbone testbenches. The word sits on mprj_io[25:20] (stage) and mprj_io[37:36] (flags). A background scrubber majority-votes the three copies, repairs any divergent copy and counts the corrections. A fault-injection register lets firmware and benches upset one copy on purpose.

---
 rtl/wb_tmr_status.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb_tmr_status.sv
// wb_tmr_status
//
// Wishbone slave that holds the firmware-visible test status word
// {flags[1:0], stage[5:0]} in three redundant copies. It drives the voted
// word onto the user GPIO pads. A background scrubber repairs any copy that
// disagrees with the vote and counts the repairs. An inject register lets
// software upset one copy on purpose.
//
// Ports
//   wb_clk_i   : single clock
//   wb_rst_i   : synchronous active-high reset
//   wbs_*      : Wishbone slave (classic, one-cycle ack pulse)
//   io_out     : pads; [25:20] = stage, [37:36] = flags, all others 0
//   io_oeb     : pad output enables (active-low); 0 only on the status pads
//
// Register map (byte offsets from BASE_ADDR)
//   0x00 STAGE  : W lane0[5:0] -> stage of all copies; R {26'b0, V[5:0]}
//   0x04 FLAGS  : W lane0[1:0] -> flags of all copies; R {30'b0, V[7:6]}
//   0x08 ERRCNT : R {16'b0, errcnt}; any write clears it
//   0x0C INJECT : W lane0 = XOR mask, lane1[9:8] = copy (3 = none); R 0

module wb_tmr_status #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FIX  = 1'b1
  } scrub_state_e;

  scrub_state_e    state_q, state_d;
  logic [2:0][7:0] copy_q, copy_d;
  logic [15:0]     errcnt_q, errcnt_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [7:0]      pad_q, pad_d;

  logic [7:0] vote;
  logic       diverge;
  logic       in_window;
  logic       req;
  logic [1:0] reg_sel;
  logic       wr_stage, wr_flags, wr_errcnt, wr_inject;
  logic       commit;
  logic [7:0] inj_mask;
  logic [1:0] inj_copy;
  logic       unused_bits;

  // Bitwise 2-of-3 majority vote across the copies.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_vote
      assign vote[gi] = (copy_q[0][gi] & copy_q[1][gi]) |
                        (copy_q[0][gi] & copy_q[2][gi]) |
                        (copy_q[1][gi] & copy_q[2][gi]);
    end
  endgenerate

  assign diverge = (copy_q[0] != vote) || (copy_q[1] != vote) || (copy_q[2] != vote);

  // Bus decode. Masking with ack keeps a held strobe from being taken twice,
  // so each request gets exactly one ack pulse.
  assign in_window = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req       = wbs_cyc_i & wbs_stb_i & in_window & ~ack_q;
  assign reg_sel   = wbs_adr_i[3:2];

  assign wr_stage  = req & wbs_we_i & (reg_sel == 2'd0) & wbs_sel_i[0];
  assign wr_flags  = req & wbs_we_i & (reg_sel == 2'd1) & wbs_sel_i[0];
  assign wr_errcnt = req & wbs_we_i & (reg_sel == 2'd2);
  assign wr_inject = req & wbs_we_i & (reg_sel == 2'd3) & wbs_sel_i[0] & wbs_sel_i[1];
  assign commit    = wr_stage | wr_flags | wr_errcnt | wr_inject;

  assign inj_mask  = wbs_dat_i[7:0];
  assign inj_copy  = wbs_dat_i[9:8];

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:10], wbs_sel_i[3:2]};

  // Scrubber, copies and error counter.
  always_comb begin
    state_d  = state_q;
    copy_d   = copy_q;
    errcnt_d = errcnt_q;

    case (state_q)
      S_IDLE: begin
        if (diverge && !commit) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        // A committing bus write takes priority over the repair; the
        // scrubber will come back if copies still disagree afterwards.
        if (!commit) begin
          for (int i = 0; i < 3; i++) begin
            copy_d[i] = vote;
          end
          if (errcnt_q != 16'hFFFF) begin
            errcnt_d = errcnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_stage) begin
      for (int i = 0; i < 3; i++) begin
        copy_d[i][5:0] = wbs_dat_i[5:0];
      end
    end
    if (wr_flags) begin
      for (int i = 0; i < 3; i++) begin
        copy_d[i][7:6] = wbs_dat_i[1:0];
      end
    end
    if (wr_inject) begin
      case (inj_copy)
        2'd0:    copy_d[0] = copy_q[0] ^ inj_mask;
        2'd1:    copy_d[1] = copy_q[1] ^ inj_mask;
        2'd2:    copy_d[2] = copy_q[2] ^ inj_mask;
        default: ;
      endcase
    end
    if (wr_errcnt) begin
      errcnt_d = 16'd0;
    end
  end

  // Bus response: read data is registered with the ack and is zero otherwise.
  always_comb begin
    ack_d = req;
    dat_d = 32'd0;
    if (req && !wbs_we_i) begin
      case (reg_sel)
        2'd0:    dat_d = {26'd0, vote[5:0]};
        2'd1:    dat_d = {30'd0, vote[7:6]};
        2'd2:    dat_d = {16'd0, errcnt_q};
        default: dat_d = 32'd0;
      endcase
    end
  end

  // Pads follow the vote one cycle later, so a single upset never shows.
  always_comb begin
    pad_d = vote;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      copy_q   <= {3{8'hFF}};
      errcnt_q <= 16'd0;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      pad_q    <= 8'hFF;
    end else begin
      state_q  <= state_d;
      copy_q   <= copy_d;
      errcnt_q <= errcnt_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      pad_q    <= pad_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  assign io_out = {pad_q[7:6], 10'd0, pad_q[5:0], 20'd0};
  assign io_oeb = {2'b00, 10'h3FF, 6'b000000, 20'hFFFFF};

endmodule
